pulse_width_decoder: RTL and testbench

- Receive-side counterpart of the pulse extender. It measures the high time of an incoming (extended) pulse and recovers one event per pulse.
- Each event is reported as a single-cycle strobe carrying the measured width in clock cycles.
- Pulses shorter than a programmable minimum width are rejected as glitches. The minimum is programmed over the same set/ack configuration interface the extender uses.
- Sits on the sampling side of a pulse link, after a pad or an extender output.

---
 rtl/pulse_pkg.sv | 12 +
 rtl/sync_chain.sv | 30 +++
 rtl/pulse_width_decoder.sv | 110 +++++++++++
 tb/tb_pulse_width_decoder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse link blocks (extender and width decoder).
package pulse_pkg;

    localparam int unsigned CNT_W_DEFAULT = 8;
    localparam int unsigned MIN_WIDTH_RST = 1;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

endpackage

// File: rtl/sync_chain.sv
// Parameterised flop synchronizer with async active-low clear; STAGES=0 is a wire.
module sync_chain #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    generate
        if (STAGES == 0) begin : g_bypass
            assign q = d;
        end else begin : g_flops
            logic [STAGES-1:0] ff;

            // Shift towards the MSB; the MSB is the synchronized output.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ff <= '0;
                end else begin
                    ff <= STAGES'({ff, d});
                end
            end

            assign q = ff[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/pulse_width_decoder.sv
// Measures the high time of each incoming pulse and emits one strobe per pulse,
// rejecting pulses shorter than a programmable minimum width as glitches.
module pulse_width_decoder
    import pulse_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             in_clock,
    input  logic             in_reset_n,
    input  logic             in_set,
    input  logic [CNT_W-1:0] in_value,
    output logic             out_ack,
    input  logic             in_signal,
    output logic             out_valid,
    output logic [CNT_W-1:0] out_width,
    output logic             out_sat,
    output logic             out_glitch
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             sig_s;
    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [CNT_W-1:0] min_width;
    logic             valid_n;
    logic             glitch_n;
    logic             sat_n;
    logic [CNT_W-1:0] width_n;

    sync_chain #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (in_clock),
        .rst_n(in_reset_n),
        .d    (in_signal),
        .q    (sig_s)
    );

    // Configuration register; a zero minimum is clamped to one cycle.
    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            min_width <= CNT_W'(MIN_WIDTH_RST);
            out_ack   <= 1'b0;
        end else begin
            out_ack <= in_set;
            if (in_set) begin
                min_width <= (in_value == '0) ? CNT_W'(1) : in_value;
            end
        end
    end

    // Next-state, counter and strobe decode.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        valid_n  = 1'b0;
        glitch_n = 1'b0;
        sat_n    = 1'b0;
        width_n  = '0;
        case (state)
            IDLE: begin
                if (sig_s) begin
                    cnt_n   = CNT_W'(1);
                    state_n = MEASURE;
                end
            end
            MEASURE: begin
                if (sig_s) begin
                    if (cnt != CNT_MAX) begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end else begin
                    // Evaluation edge: counter holds the full width, saturation is sticky at max.
                    state_n = IDLE;
                    cnt_n   = '0;
                    if (cnt >= min_width) begin
                        valid_n = 1'b1;
                        width_n = cnt;
                        sat_n   = (cnt == CNT_MAX);
                    end else begin
                        glitch_n = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            out_valid  <= 1'b0;
            out_glitch <= 1'b0;
            out_sat    <= 1'b0;
            out_width  <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            out_valid  <= valid_n;
            out_glitch <= glitch_n;
            out_sat    <= sat_n;
            out_width  <= width_n;
        end
    end

endmodule

// File: tb/tb_pulse_width_decoder.sv
// Bench for pulse_width_decoder: table-driven pulse scenarios, hand sequences and
// random pulses, all checked every cycle against a run-length reference model.
module tb_pulse_width_decoder;

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned STAGES = 2;
    localparam int          MAXW   = 255;

    logic             clk;
    logic             rst_n;
    logic             set_i;
    logic [CNT_W-1:0] value;
    logic             ack;
    logic             sig;
    logic             valid;
    logic [CNT_W-1:0] width;
    logic             sat;
    logic             glitch;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: input delay line plus a plain run-length count.
    logic m_dq [STAGES];
    int   m_run;
    int   m_minw;
    logic e_ack, e_valid, e_sat, e_glitch;
    int   e_width;

    // Strobe observations.
    int n_valid, n_glitch, got_width;
    logic got_sat;
    int vcyc[$];
    int vwid[$];

    typedef struct {
        logic set;
        int   val;
        int   high;
        int   low;
        logic x_valid;
        logic x_glitch;
        int   x_width;
        logic x_sat;
    } vec_t;

    vec_t vecs[7];

    pulse_width_decoder #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(STAGES)
    ) dut (
        .in_clock  (clk),
        .in_reset_n(rst_n),
        .in_set    (set_i),
        .in_value  (value),
        .out_ack   (ack),
        .in_signal (sig),
        .out_valid (valid),
        .out_width (width),
        .out_sat   (sat),
        .out_glitch(glitch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", name, got, exp, cyc, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < STAGES; i++) m_dq[i] = 1'b0;
        m_run    = 0;
        m_minw   = 1;
        e_ack    = 1'b0;
        e_valid  = 1'b0;
        e_sat    = 1'b0;
        e_glitch = 1'b0;
        e_width  = 0;
    endtask

    task automatic model_edge(input logic s, input logic st, input int v);
        logic ss;
        int   w;
        ss = m_dq[STAGES-1];
        for (int i = STAGES - 1; i > 0; i--) m_dq[i] = m_dq[i-1];
        m_dq[0] = s;
        e_ack    = st;
        e_valid  = 1'b0;
        e_glitch = 1'b0;
        e_sat    = 1'b0;
        e_width  = 0;
        if (ss) begin
            m_run++;
        end else if (m_run > 0) begin
            w = (m_run > MAXW) ? MAXW : m_run;
            if (w >= m_minw) begin
                e_valid = 1'b1;
                e_width = w;
                e_sat   = (m_run >= MAXW);
            end else begin
                e_glitch = 1'b1;
            end
            m_run = 0;
        end
        if (st) m_minw = (v == 0) ? 1 : v;
    endtask

    // One clock: drive after the falling edge, model at the rising edge, check 1 time unit later.
    task automatic step(input logic s, input logic st, input int v);
        sig   = s;
        set_i = st;
        value = CNT_W'(v);
        @(posedge clk);
        model_edge(s, st, v);
        #1;
        cyc++;
        chk("ack", int'(ack), int'(e_ack));
        chk("valid", int'(valid), int'(e_valid));
        chk("glitch", int'(glitch), int'(e_glitch));
        chk("width", int'(width), e_width);
        chk("sat", int'(sat), int'(e_sat));
        if (valid) begin
            n_valid++;
            got_width = int'(width);
            got_sat   = sat;
            vcyc.push_back(cyc);
            vwid.push_back(int'(width));
        end
        if (glitch) begin
            n_glitch++;
            got_width = int'(width);
        end
        @(negedge clk);
    endtask

    task automatic clear_obs();
        n_valid   = 0;
        n_glitch  = 0;
        got_width = -1;
        got_sat   = 1'b0;
        vcyc.delete();
        vwid.delete();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ack"}, int'(ack), 0);
        chk({tag, "_valid"}, int'(valid), 0);
        chk({tag, "_glitch"}, int'(glitch), 0);
        chk({tag, "_width"}, int'(width), 0);
        chk({tag, "_sat"}, int'(sat), 0);
    endtask

    initial begin
        // set, val, high, low, valid, glitch, width, sat
        vecs[0] = '{1'b0, 0, 5,   5, 1'b1, 1'b0, 5,   1'b0};
        vecs[1] = '{1'b1, 4, 3,   5, 1'b0, 1'b1, 0,   1'b0};
        vecs[2] = '{1'b0, 0, 4,   5, 1'b1, 1'b0, 4,   1'b0};
        vecs[3] = '{1'b0, 0, 300, 5, 1'b1, 1'b0, 255, 1'b1};
        vecs[4] = '{1'b0, 0, 10,  5, 1'b1, 1'b0, 10,  1'b0};
        vecs[5] = '{1'b1, 0, 1,   5, 1'b1, 1'b0, 1,   1'b0};
        vecs[6] = '{1'b1, 6, 5,   5, 1'b0, 1'b1, 0,   1'b0};

        rst_n = 1'b0;
        sig   = 1'b0;
        set_i = 1'b0;
        value = '0;
        model_reset();
        #1;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven pulse scenarios.
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].set) begin
                step(1'b0, 1'b1, vecs[i].val);
                chk($sformatf("v%0d_ack_hi", i), int'(ack), 1);
                step(1'b0, 1'b0, 0);
                chk($sformatf("v%0d_ack_lo", i), int'(ack), 0);
            end
            clear_obs();
            for (int h = 0; h < vecs[i].high; h++) step(1'b1, 1'b0, 0);
            for (int l = 0; l < vecs[i].low; l++) step(1'b0, 1'b0, 0);
            chk($sformatf("v%0d_n_valid", i), n_valid, vecs[i].x_valid ? 1 : 0);
            chk($sformatf("v%0d_n_glitch", i), n_glitch, vecs[i].x_glitch ? 1 : 0);
            chk($sformatf("v%0d_width", i), got_width, vecs[i].x_width);
            chk($sformatf("v%0d_sat", i), int'(got_sat), int'(vecs[i].x_sat));
        end

        // Restore minimum of 1, then back-to-back pulses 2 high / 1 low / 7 high.
        step(1'b0, 1'b1, 1);
        step(1'b0, 1'b0, 0);
        clear_obs();
        for (int h = 0; h < 2; h++) step(1'b1, 1'b0, 0);
        step(1'b0, 1'b0, 0);
        for (int h = 0; h < 7; h++) step(1'b1, 1'b0, 0);
        for (int l = 0; l < 5; l++) step(1'b0, 1'b0, 0);
        chk("b2b_count", vcyc.size(), 2);
        if (vcyc.size() == 2) begin
            chk("b2b_w0", vwid[0], 2);
            chk("b2b_w1", vwid[1], 7);
            chk("b2b_gap", vcyc[1] - vcyc[0], 8);
        end

        // Reset asserted mid-pulse after 6 high cycles, input held high.
        clear_obs();
        for (int h = 0; h < 6; h++) step(1'b1, 1'b0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        model_reset();
        @(posedge clk);
        #1;
        check_all_zero("inrst");
        @(negedge clk);
        rst_n = 1'b1;
        clear_obs();
        for (int h = 0; h < 3; h++) step(1'b1, 1'b0, 0);
        for (int l = 0; l < 5; l++) step(1'b0, 1'b0, 0);
        chk("rst_n_valid", n_valid, 1);
        chk("rst_n_glitch", n_glitch, 0);
        chk("rst_width", got_width, 3);

        // Random pulses and reconfiguration.
        for (int p = 0; p < 40; p++) begin
            int hi;
            int lo;
            hi = int'($urandom_range(1, 20));
            lo = int'($urandom_range(1, 4));
            if ($urandom_range(0, 3) == 0) step(1'b0, 1'b1, int'($urandom_range(0, 12)));
            for (int h = 0; h < hi; h++) step(1'b1, ($urandom_range(0, 15) == 0), int'($urandom_range(0, 12)));
            for (int l = 0; l < lo; l++) step(1'b0, 1'b0, 0);
        end
        for (int l = 0; l < 5; l++) step(1'b0, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
